// File: rtl/segment_pkg.sv
// rtl/segment_pkg.sv - shared segment register types, constants and arbiter state encoding
package segment_pkg;

    typedef enum logic [1:0] {
        ES = 2'd0,
        CS = 2'd1,
        SS = 2'd2,
        DS = 2'd3
    } SR_t;

    typedef logic [1:0] sel_t;

    localparam int NUM_SEG = 4;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker starting the search at ptr
module rr_picker
    import segment_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic [PW-1:0] pos;

    // Walk the requesters from ptr upward with wrap, first active one wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = 0; k < N; k++) begin
            pos = PW'((int'(ptr) + k) % N);
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/segment_port_arbiter.sv
// rtl/segment_port_arbiter.sv - shares segment register file read/write ports among requesters
module segment_port_arbiter
    import segment_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    rd_req,
    input  logic [NUM_REQ*2-1:0]  rd_sel,
    input  logic [NUM_REQ-1:0]    wr_req,
    input  logic [NUM_REQ*2-1:0]  wr_sel,
    input  logic [NUM_REQ*16-1:0] wr_val,
    input  logic [NUM_REQ-1:0]    lock,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    rd_valid,
    output logic [15:0]           rd_data,
    output logic [1:0]            sr_rd_sel,
    input  logic [15:0]           sr_rd_val,
    output logic                  sr_wr_en,
    output logic [1:0]            sr_wr_sel,
    output logic [15:0]           sr_wr_val,
    output logic                  locked
);

    localparam int PW = ptr_width(NUM_REQ);

    arb_state_t           state_q, state_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   rd_tag_q;
    sel_t                 sel_q;

    logic [NUM_REQ-1:0]   active;
    logic [NUM_REQ-1:0]   pick_gnt;
    logic [PW-1:0]        pick_idx;
    logic                 pick_any;

    logic                 win_rd;
    logic                 win_wr;
    sel_t                 w_rd_sel;
    sel_t                 w_wr_sel;
    logic [15:0]          w_wr_val;

    assign active = rd_req | wr_req;

    rr_picker #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_picker (
        .req (active),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // State register: FSM state, lock owner and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next state: lock on a locking grant in IDLE, release on the owner's first lock-low cycle.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    rr_ptr_d = (pick_idx == PW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    if (lock[pick_idx]) begin
                        state_d = ARB_LOCKED;
                        owner_d = pick_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                if (!lock[owner_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Outputs: grant the picker's winner in IDLE or only the owner when locked, then steer its port fields.
    always_comb begin
        grant = '0;
        if (reset) begin
            if (state_q == ARB_IDLE) begin
                grant = pick_gnt;
            end else begin
                grant[owner_q] = active[owner_q];
            end
        end
        win_rd   = 1'b0;
        win_wr   = 1'b0;
        w_rd_sel = sel_q;
        w_wr_sel = '0;
        w_wr_val = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_rd   = rd_req[i];
                win_wr   = wr_req[i];
                if (rd_req[i]) begin
                    w_rd_sel = rd_sel[2*i +: 2];
                end
                w_wr_sel = wr_sel[2*i +: 2];
                w_wr_val = wr_val[16*i +: 16];
            end
        end
    end

    // Read tag and held read select; the tag marks whose data returns next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_tag_q <= '0;
            sel_q    <= '0;
        end else begin
            rd_tag_q <= grant & rd_req;
            if (win_rd) begin
                sel_q <= w_rd_sel;
            end
        end
    end

    assign sr_rd_sel = reset ? w_rd_sel : 2'd0;
    assign sr_wr_en  = win_wr;
    assign sr_wr_sel = w_wr_sel;
    assign sr_wr_val = w_wr_val;
    assign rd_valid  = rd_tag_q;
    assign rd_data   = sr_rd_val;
    assign locked    = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_segment_port_arbiter.sv
// tb/tb_segment_port_arbiter.sv - self-checking bench for segment_port_arbiter
module tb_segment_port_arbiter;
    import segment_pkg::*;

    localparam int N = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     rd_req, wr_req, lock;
    logic [2*N-1:0]   rd_sel, wr_sel;
    logic [16*N-1:0]  wr_val;
    logic [N-1:0]     grant, rd_valid;
    logic [15:0]      rd_data, sr_rd_val, sr_wr_val;
    logic [1:0]       sr_rd_sel, sr_wr_sel;
    logic             sr_wr_en, locked;

    logic [1:0]       rs [N];
    logic [1:0]       ws [N];
    logic [15:0]      wv [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign rd_sel[2*g +: 2]  = rs[g];
        assign wr_sel[2*g +: 2]  = ws[g];
        assign wr_val[16*g +: 16] = wv[g];
    end

    segment_port_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_sel    (rd_sel),
        .wr_req    (wr_req),
        .wr_sel    (wr_sel),
        .wr_val    (wr_val),
        .lock      (lock),
        .grant     (grant),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .sr_rd_sel (sr_rd_sel),
        .sr_rd_val (sr_rd_val),
        .sr_wr_en  (sr_wr_en),
        .sr_wr_sel (sr_wr_sel),
        .sr_wr_val (sr_wr_val),
        .locked    (locked)
    );

    // Register file environment: registered read with write bypass.
    logic [15:0] rf [4];
    always @(posedge clk) begin
        sr_rd_val <= (sr_wr_en && sr_wr_sel == sr_rd_sel) ? sr_wr_val : rf[sr_rd_sel];
        if (sr_wr_en) rf[sr_wr_sel] <= sr_wr_val;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the arbitration rules.
    bit          m_locked = 1'b0;
    int          m_owner  = 0;
    int          m_ptr    = 0;
    logic [N-1:0] m_tag   = '0;
    logic [15:0] m_tdata  = '0;
    logic [1:0]  m_rdsel  = '0;
    logic [15:0] m_regs [4];
    int          w;
    logic [1:0]  esel;

    always @(negedge clk) begin
        w = -1;
        if (reset) begin
            if (m_locked) begin
                if (rd_req[m_owner] || wr_req[m_owner]) w = m_owner;
            end else begin
                for (int k = 0; k < N; k++)
                    if (w < 0 && (rd_req[(m_ptr + k) % N] || wr_req[(m_ptr + k) % N]))
                        w = (m_ptr + k) % N;
            end
        end
        check("m_grant", grant, (w >= 0) ? (32'd1 << w) : 32'd0);
        check("m_wr_en", sr_wr_en, (w >= 0 && wr_req[w]) ? 32'd1 : 32'd0);
        if (w >= 0 && wr_req[w]) begin
            check("m_wr_sel", sr_wr_sel, ws[w]);
            check("m_wr_val", sr_wr_val, wv[w]);
        end
        esel = m_rdsel;
        if (!reset) esel = 2'd0;
        else if (w >= 0 && rd_req[w]) esel = rs[w];
        check("m_rd_sel", sr_rd_sel, esel);
        check("m_locked", locked, m_locked);
        check("m_rd_valid", rd_valid, m_tag);
        if (m_tag != 0) check("m_rd_data", rd_data, m_tdata);

        if (!reset) begin
            m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_tag = '0; m_rdsel = 2'd0;
        end else begin
            m_tag = '0;
            if (w >= 0 && rd_req[w]) begin
                m_tag[w] = 1'b1;
                m_tdata  = (wr_req[w] && ws[w] == rs[w]) ? wv[w] : m_regs[rs[w]];
                m_rdsel  = rs[w];
            end
            if (w >= 0 && wr_req[w]) m_regs[ws[w]] = wv[w];
            if (m_locked) begin
                if (!lock[m_owner]) m_locked = 1'b0;
            end else if (w >= 0) begin
                m_ptr = (w + 1) % N;
                if (lock[w]) begin
                    m_locked = 1'b1;
                    m_owner  = w;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk); #1;
    endtask

    task automatic clear();
        rd_req = '0; wr_req = '0; lock = '0;
    endtask

    int waits;

    initial begin
        rf[0] = 16'h0E5E; rf[1] = 16'hC5C5; rf[2] = 16'h5555; rf[3] = 16'hD5D5;
        m_regs[0] = 16'h0E5E; m_regs[1] = 16'hC5C5; m_regs[2] = 16'h5555; m_regs[3] = 16'hD5D5;
        reset = 1'b0;
        clear();
        for (int i = 0; i < N; i++) begin rs[i] = CS; ws[i] = ES; wv[i] = '0; end

        // Reset held with every requester reading
        rd_req = '1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("rst_grant", grant, 0);
            check("rst_wr_en", sr_wr_en, 0);
            check("rst_rd_valid", rd_valid, 0);
            check("rst_locked", locked, 0);
            step();
        end

        // Release, round robin on CS reads
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            sample();
            check("rr_grant", grant, 32'd1 << (c % 3));
            if (c > 0) begin
                check("rr_rd_valid", rd_valid, 32'd1 << ((c - 1) % 3));
                check("rr_rd_data", rd_data, 16'hC5C5);
            end
            step();
        end
        clear();
        sample();
        check("rr_last_valid", rd_valid, 3'b100);
        check("rr_last_data", rd_data, 16'hC5C5);
        step();

        // Write and read SS in one grant
        rd_req[1] = 1'b1; rs[1] = SS;
        wr_req[1] = 1'b1; ws[1] = SS; wv[1] = 16'h1234;
        sample();
        check("byp_grant", grant, 3'b010);
        check("byp_wr_en", sr_wr_en, 1);
        step(); clear();
        sample();
        check("byp_rd_valid", rd_valid, 3'b010);
        check("byp_rd_data", rd_data, 16'h1234);
        step();

        // Locked sequence by requester 1 while requester 0 waits
        wr_req[1] = 1'b1; ws[1] = CS; wv[1] = 16'hF000; lock[1] = 1'b1;
        sample();
        check("lk_a_grant", grant, 3'b010);
        check("lk_a_locked", locked, 0);
        step();
        ws[1] = ES; wv[1] = 16'h0ABC; rd_req[0] = 1'b1; rs[0] = DS;
        sample();
        check("lk_b_grant", grant, 3'b010);
        check("lk_b_locked", locked, 1);
        step();
        wr_req[1] = 1'b0; rd_req[1] = 1'b1; rs[1] = SS;
        sample();
        check("lk_c_grant", grant, 3'b010);
        check("lk_c_locked", locked, 1);
        step();
        rd_req[1] = 1'b0; lock[1] = 1'b0;
        sample();
        check("lk_d_grant", grant, 3'b000);
        check("lk_d_locked", locked, 1);
        check("lk_d_rd_valid", rd_valid, 3'b010);
        check("lk_d_rd_data", rd_data, 16'h1234);
        step();
        sample();
        check("lk_e_grant", grant, 3'b001);
        check("lk_e_locked", locked, 0);
        step(); clear();
        sample();
        check("lk_e_rd_valid", rd_valid, 3'b001);
        check("lk_e_rd_data", rd_data, 16'hD5D5);
        step();

        // Reset while locked with a read requested
        wr_req[1] = 1'b1; ws[1] = DS; wv[1] = 16'h7777; lock[1] = 1'b1;
        sample();
        check("rl_grant", grant, 3'b010);
        step();
        wr_req[1] = 1'b0; rd_req[1] = 1'b1; rs[1] = CS;
        rd_req[0] = 1'b1; rs[0] = ES;
        reset = 1'b0;
        sample();
        check("rl_rst_grant", grant, 0);
        check("rl_rst_wr_en", sr_wr_en, 0);
        step();
        sample();
        check("rl_rd_valid", rd_valid, 0);
        check("rl_locked", locked, 0);
        step();

        // Release; requester 2 holds a DS write against saturating readers
        reset = 1'b1; lock = '0;
        wr_req[2] = 1'b1; ws[2] = DS; wv[2] = 16'hBEEF;
        sample();
        check("rl_first_grant", grant, 3'b001);
        waits = 0;
        while (!grant[2] && waits < 6) begin
            step(); sample();
            waits++;
        end
        check("hold_wait", waits, 2);
        check("hold_wr", (sr_wr_en && sr_wr_sel == DS && sr_wr_val == 16'hBEEF) ? 32'd1 : 32'd0, 1);
        step(); clear();
        rd_req[2] = 1'b1; rs[2] = DS;
        sample();
        check("hold_rd_grant", grant, 3'b100);
        step(); clear();
        sample();
        check("hold_rd_valid", rd_valid, 3'b100);
        check("hold_rd_data", rd_data, 16'hBEEF);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/segment_port_arbiter.md
# segment_port_arbiter

Shares the single read port and single write port of the segment register file between up to `NUM_REQ` requesters: the microcode execute unit, the interrupt/far-transfer sequencer and the debug unit. One requester is granted per cycle. The winner may issue a read, a write, or both. A requester can lock the ports across several cycles for atomic sequences such as a far call or an interrupt entry. The block sits directly between the requesters and the segment register file.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters. Index 0 is execute, 1 is the interrupt/far sequencer, 2 is debug.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous and active-low.
- `rd_req`  in  NUM_REQ: per-requester read request.
- `rd_sel`  in  NUM_REQ×2: per-requester segment select (ES=0, CS=1, SS=2, DS=3).
- `wr_req`  in  NUM_REQ: per-requester write request.
- `wr_sel`  in  NUM_REQ×2: per-requester write select.
- `wr_val`  in  NUM_REQ×16: per-requester write data.
- `lock`  in  NUM_REQ: request to hold ownership after the current grant.
- `grant`  out  NUM_REQ: one-hot, combinational. Accepts the winner's rd_req/wr_req this cycle.
- `rd_valid`  out  NUM_REQ: one-hot, registered. Read data is valid for that requester.
- `rd_data`  out  16: broadcast read data, equal to `sr_rd_val`.
- `sr_rd_sel`  out  2: to the register file read select.
- `sr_rd_val`  in  16: from the register file. Registered there, one cycle after `sr_rd_sel`.
- `sr_wr_en`, `sr_wr_sel`, `sr_wr_val`  out  1/2/16: to the register file write port.
- `locked`  out  1: ports are currently owned.

## Operation
- A requester is active when `rd_req[i] | wr_req[i]`.
- State machine:
  - IDLE: round-robin among active requesters. The search starts at `rr_ptr`.
  - LOCKED(owner): only `owner` can be granted. All other requesters stall with `grant` low.
- Transitions:
  - IDLE → LOCKED(i) when `grant[i]` and `lock[i]` are both high.
  - LOCKED(o) → IDLE at the first cycle with `lock[o]` low, whether or not `o` requests in that cycle. A grant issued in that same cycle still completes.
- `rr_ptr` updates only on a grant in IDLE. It becomes (winner+1) mod NUM_REQ. It is unchanged in LOCKED.
- Port steering:
  - `sr_rd_sel` = winner's `rd_sel` when the winner has `rd_req`. Otherwise it holds its previous value.
  - `sr_wr_en` = grant & wr_req of the winner. `sr_wr_sel`/`sr_wr_val` come from the winner.
- Read return: a registered tag captures grant & rd_req. Next cycle `rd_valid[tag]` = 1 and `rd_data` = `sr_rd_val`.
- Read and write to the same register in one grant: the read returns the new value, because the register file bypasses it.
- Requests are level-sensitive. A requester keeps `rd_req`/`wr_req` and its data stable until it sees `grant`.
- `NUM_REQ`=1 degenerates to a pass-through with a one-cycle `rd_valid`.

## Timing
- Values while `reset` is low:
  - state = IDLE, `rr_ptr` = 0, `locked` = 0.
  - `rd_valid` = 0 on the next edge.
  - `grant` = 0 and `sr_wr_en` = 0 combinationally, for the whole time reset is low.
  - `sr_rd_sel` = 0.
- Reset mid-operation drops any pending `rd_valid` and releases a lock. No write is issued during reset.
- Grant latency: 0 cycles. Read latency: `rd_valid` 1 cycle after `grant`. Write: the register file updates at the edge ending the grant cycle.
- Back-to-back grants to different requesters every cycle are allowed. `rd_valid` pulses track their owners in order.
- Bounded latency in IDLE: at most NUM_REQ-1 cycles of wait. LOCKED has no timeout; the owner guarantees release.

## Structure
- Shared package `segment_pkg`:
  - `SR_t` enum (ES, CS, SS, DS).
  - 2-bit select type.
  - `NUM_SEG` = 4.
- Sub-module `rr_picker`: parameterized round-robin priority picker.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: one-hot `gnt`, `idx`, `any`.
  - Purely combinational.
- The top level holds the state machine, `rr_ptr`, the read tag register and the muxing.

## Test plan
1. Reset: hold `reset`=0 with all `rd_req`=1. Required: `grant`=0, `sr_wr_en`=0, `rd_valid`=0. On release the first grant goes to requester 0.
2. Round robin: all three assert `rd_req` with sel CS continuously. Required: grants 0,1,2,0… and `rd_valid` 0,1,2 each one cycle later. `rd_data` is the CS value.
3. Write then read bypass: requester 1 sets `wr_req`, `wr_sel`=SS, `wr_val`=16'h1234, plus `rd_req`, `rd_sel`=SS in the same cycle. Required: `rd_valid[1]` next cycle with `rd_data`=16'h1234.
4. Lock: requester 1 sets `lock`=1 for 3 grants (write CS=16'hF000, write IP-side, read SS) while requester 0 requests. Required: requester 0 sees no grant until the cycle after `lock[1]` drops. `locked`=1 throughout the sequence.
5. Reset mid-lock: assert `reset` while LOCKED(1) with a read in flight. Required: no `rd_valid`, `locked`=0, and the first post-reset grant goes to requester 0.
6. Hold: requester 2 holds `wr_req`, DS=16'hBEEF for several cycles while 0 and 1 saturate the ports. Required: granted within 2 cycles and DS reads back 16'hBEEF.
